// File: rtl/calc_req_scheduler.sv
// calc_req_scheduler: four requesters share one calc1-style ALU port.
// Each requester delivers a two-beat request (cmd+op1, then op2). Requests are
// arbitrated onto the single downstream port one at a time. The ALU response,
// or a timeout, is routed back to the originating requester as a one-cycle pulse.
// Build option: define FIXED_PRIO_EN for fixed priority (port 1 highest).
// Without it, arbitration is round-robin.
module calc_req_scheduler #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req1_cmd_in,
  input  logic [31:0] req1_data_in,
  input  logic [3:0]  req2_cmd_in,
  input  logic [31:0] req2_data_in,
  input  logic [3:0]  req3_cmd_in,
  input  logic [31:0] req3_data_in,
  input  logic [3:0]  req4_cmd_in,
  input  logic [31:0] req4_data_in,
  output logic [1:0]  out_resp1,
  output logic [31:0] out_data1,
  output logic [1:0]  out_resp2,
  output logic [31:0] out_data2,
  output logic [1:0]  out_resp3,
  output logic [31:0] out_data3,
  output logic [1:0]  out_resp4,
  output logic [31:0] out_data4,
  output logic [3:0]  alu_cmd_out,
  output logic [31:0] alu_data_out,
  input  logic [1:0]  alu_resp_in,
  input  logic [31:0] alu_data_in
);

  typedef enum logic [1:0] {P_IDLE, P_GOT1, P_PEND} port_st_t;
  typedef enum logic [2:0] {S_IDLE, S_ARB, S_BEAT1, S_BEAT2, S_WAIT, S_DONE} fsm_t;

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;
  localparam logic [1:0] RESP_TMO = 2'd3;

  // Per-port views of the flat port list
  logic [3:0]  cmd_in  [4];
  logic [31:0] data_in [4];
  logic [1:0]  resp_o  [4];
  logic [31:0] data_o  [4];

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;
  assign out_resp1  = resp_o[0];
  assign out_resp2  = resp_o[1];
  assign out_resp3  = resp_o[2];
  assign out_resp4  = resp_o[3];
  assign out_data1  = data_o[0];
  assign out_data2  = data_o[1];
  assign out_data3  = data_o[2];
  assign out_data4  = data_o[3];

  port_st_t    pst  [4];
  logic [3:0]  pcmd [4];
  logic [31:0] pop1 [4];
  logic [31:0] pop2 [4];
  logic [3:0]  rej;        // reject pulse owed to each port
  logic [3:0]  pend;
  logic [3:0]  done_hit;   // port whose real response is on the outputs this cycle

  fsm_t             state, state_nx;
  logic [1:0]       grant, grant_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       res_resp;
  logic [31:0]      res_data;
  logic             timeout;
`ifndef FIXED_PRIO_EN
  logic [1:0]       last_grant;
  logic [1:0]       idx;
`endif

  assign timeout = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Decode pending ports and the port currently receiving its response
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pend     = '0;
    done_hit = '0;
    for (int i = 0; i < 4; i++) begin
      pend[i]     = (pst[i] == P_PEND);
      done_hit[i] = (state == S_DONE) && (grant == 2'(i));
    end
  end

  // Per-port capture state machine and reject bookkeeping
  always_ff @(posedge c_clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!reset) begin
      for (int i = 0; i < 4; i++) pst[i] <= P_IDLE;
      rej <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        // An owed reject is held back while the real response occupies the port.
        if (rej[i] && !done_hit[i]) rej[i] <= 1'b0;
        case (pst[i])
          P_IDLE: if (cmd_in[i] != '0) pst[i] <= P_GOT1;
          P_GOT1: pst[i] <= P_PEND;
          P_PEND: begin
            if (cmd_in[i] != '0) rej[i] <= 1'b1;
            if (done_hit[i]) pst[i] <= P_IDLE;
          end
          default: pst[i] <= P_IDLE;
        endcase
      end
    end
  end

  // Request payload capture
  always_ff @(posedge c_clk) begin
    // NOTE: payload storage has no reset; it is only read while the port state marks it valid.
    for (int i = 0; i < 4; i++) begin
      if (pst[i] == P_IDLE && cmd_in[i] != '0) begin
        pcmd[i] <= cmd_in[i];
        pop1[i] <= data_in[i];
      end else if (pst[i] == P_GOT1) begin
        pop2[i] <= data_in[i];
      end
    end
  end

  // Grant selection among pending ports
`ifdef FIXED_PRIO_EN
  always_comb begin
    grant_nx = grant;
    for (int k = 3; k >= 0; k--) begin
      if (pend[k]) grant_nx = 2'(k);
    end
  end
`else
  always_comb begin
    grant_nx = last_grant;
    idx      = last_grant;
    for (int k = 4; k >= 1; k--) begin
      idx = last_grant + 2'(k);
      if (pend[idx]) grant_nx = idx;
    end
  end
`endif

  // Scheduler state register, grant, timeout counter and captured response
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      grant      <= '0;
`ifndef FIXED_PRIO_EN
      last_grant <= 2'd3;
`endif
      cnt        <= '0;
      res_resp   <= '0;
      res_data   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_ARB: begin
          grant      <= grant_nx;
`ifndef FIXED_PRIO_EN
          last_grant <= grant_nx;
`endif
        end
        S_WAIT: begin
          if (alu_resp_in != '0) begin
            res_resp <= alu_resp_in;
            res_data <= (alu_resp_in == RESP_OK) ? alu_data_in : '0;
          end else if (timeout) begin
            res_resp <= RESP_TMO;
            res_data <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE:  cnt <= '0;
        default: ;
      endcase
    end
  end

  // Scheduler next state and downstream beats
  always_comb begin
    state_nx     = state;
    alu_cmd_out  = '0;
    alu_data_out = '0;
    case (state)
      S_IDLE:  if (|pend) state_nx = S_ARB;
      S_ARB:   state_nx = (|pend) ? S_BEAT1 : S_IDLE;
      S_BEAT1: begin
        alu_cmd_out  = pcmd[grant];
        alu_data_out = pop1[grant];
        state_nx     = S_BEAT2;
      end
      S_BEAT2: begin
        alu_data_out = pop2[grant];
        state_nx     = S_WAIT;
      end
      S_WAIT:  if (alu_resp_in != '0 || timeout) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Response pulses back to requesters; real response outranks an owed reject
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      resp_o[i] = '0;
      data_o[i] = '0;
      if (done_hit[i]) begin
        resp_o[i] = res_resp;
        data_o[i] = res_data;
      end else if (rej[i]) begin
        resp_o[i] = RESP_ERR;
      end
    end
  end

endmodule
